// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, FSM states
// and active-low gfedcba segment patterns.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned HEX_W      = 4;
    localparam int unsigned SEG_W      = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [HEX_W-1:0] i_hex,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_OFF;
        case (i_hex)
            4'h0: o_seg_c = SEG_0;
            4'h1: o_seg_c = SEG_1;
            4'h2: o_seg_c = SEG_2;
            4'h3: o_seg_c = SEG_3;
            4'h4: o_seg_c = SEG_4;
            4'h5: o_seg_c = SEG_5;
            4'h6: o_seg_c = SEG_6;
            4'h7: o_seg_c = SEG_7;
            4'h8: o_seg_c = SEG_8;
            4'h9: o_seg_c = SEG_9;
            4'hA: o_seg_c = SEG_A;
            4'hB: o_seg_c = SEG_B;
            4'hC: o_seg_c = SEG_C;
            4'hD: o_seg_c = SEG_D;
            4'hE: o_seg_c = SEG_E;
            4'hF: o_seg_c = SEG_F;
            default: o_seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Four-digit common-anode scan driver with a per-frame snapshot of the
// digit values so a mid-frame demux update never tears the display.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic [HEX_W-1:0]      d0,
    input  logic [HEX_W-1:0]      d1,
    input  logic [HEX_W-1:0]      d2,
    input  logic [HEX_W-1:0]      d3,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int unsigned       CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                              r_state;
    state_t                              w_next_state;
    logic [CNT_W-1:0]                    r_cnt;
    logic [CNT_W-1:0]                    w_cnt_next;
    logic [IDX_W-1:0]                    r_idx;
    logic [IDX_W-1:0]                    w_idx_next;
    logic [NUM_DIGITS-1:0][HEX_W-1:0]    r_snap;
    logic [NUM_DIGITS-1:0]               r_snap_blank;
    logic [NUM_DIGITS-1:0]               r_snap_dp;
    logic                                r_frame_pulse;
    logic                                w_capture;
    logic                                w_wrap;
    logic [SEG_W-1:0]                    w_seg_dec;

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, slot counter and digit index advance
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = SCAN;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_capture    = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    w_idx_next = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_wrap    = 1'b1;
                        w_capture = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // Counters, snapshot and frame pulse
    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_snap        <= '0;
            r_snap_blank  <= '0;
            r_snap_dp     <= '0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_frame_pulse <= w_wrap;
            if (w_capture) begin
                r_snap       <= {d3, d2, d1, d0};
                r_snap_blank <= blank;
                r_snap_dp    <= dp_in;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .i_hex   (r_snap[r_idx]),
        .o_seg_c (w_seg_dec)
    );

    // Output register, driven from the pre-edge state
    always_ff @(posedge clk) begin
        if (res) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            digit_idx  <= r_idx;
            frame_done <= r_frame_pulse;
            if (r_state == IDLE || r_snap_blank[r_idx]) begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << r_idx);
                seg <= w_seg_dec;
                dp  <= ~r_snap_dp[r_idx];
            end
        end
    end

endmodule
